// File: rtl/basic_gate_pkg.sv
// Shared types and constants for the basic_gate BIST controller.
package basic_gate_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam int unsigned NUM_GATES   = 7;
  localparam int unsigned NUM_VECTORS = 4;
  localparam int unsigned VEC_W       = 2;

  localparam int unsigned GATE_NOT  = 0;
  localparam int unsigned GATE_AND  = 1;
  localparam int unsigned GATE_NAND = 2;
  localparam int unsigned GATE_OR   = 3;
  localparam int unsigned GATE_NOR  = 4;
  localparam int unsigned GATE_XOR  = 5;
  localparam int unsigned GATE_XNOR = 6;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/basic_gate_golden.sv
// Reference model of the basic_gate datapath: (a,b) -> expected 7-bit gate vector.
module basic_gate_golden
  import basic_gate_pkg::*;
(
  input  logic                 a_i,
  input  logic                 b_i,
  output logic [NUM_GATES-1:0] golden_c
);

  // Pure combinational truth table, bit order {xnor,xor,nor,or,nand,and,not}.
  always_comb begin
    golden_c            = '0;
    golden_c[GATE_NOT]  = ~a_i;
    golden_c[GATE_AND]  = a_i & b_i;
    golden_c[GATE_NAND] = ~(a_i & b_i);
    golden_c[GATE_OR]   = a_i | b_i;
    golden_c[GATE_NOR]  = ~(a_i | b_i);
    golden_c[GATE_XOR]  = a_i ^ b_i;
    golden_c[GATE_XNOR] = ~(a_i ^ b_i);
  end

endmodule

// File: rtl/basic_gate_bist_ctrl.sv
// BIST controller for basic_gate: walks all four input vectors, compares
// the seven gate outputs with a golden model, reports pass/done/err_mask.
// Optional first-failure log enabled by defining BASIC_GATE_BIST_LOG_EN.
module basic_gate_bist_ctrl
  import basic_gate_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned LOOPS         = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_GATES-1:0] gate_out,
  output logic                 in_a,
  output logic                 in_b,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] err_mask
`ifdef BASIC_GATE_BIST_LOG_EN
  ,
  output logic                 fail_valid,
  output logic [VEC_W-1:0]     fail_vec,
  output logic [NUM_GATES-1:0] fail_obs
`endif
);

  localparam int unsigned CNT_W  = cnt_width(SETTLE_CYCLES);
  localparam int unsigned LOOP_W = cnt_width(LOOPS);

  state_e               state_q, state_d;
  logic [VEC_W-1:0]     vec_q, vec_d;
  logic [LOOP_W-1:0]    loop_q, loop_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 in_a_q, in_a_d;
  logic                 in_b_q, in_b_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [NUM_GATES-1:0] err_q, err_d;
  logic [NUM_GATES-1:0] golden_c;
  logic [NUM_GATES-1:0] mism_c;
`ifdef BASIC_GATE_BIST_LOG_EN
  logic                 fvalid_q, fvalid_d;
  logic [VEC_W-1:0]     fvec_q, fvec_d;
  logic [NUM_GATES-1:0] fobs_q, fobs_d;
`endif

  // Expected outputs for the vector currently driven on the pins.
  basic_gate_golden u_golden (
    .a_i      (vec_q[0]),
    .b_i      (vec_q[1]),
    .golden_c (golden_c)
  );

  assign mism_c = gate_out ^ golden_c;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      loop_q   <= '0;
      cnt_q    <= '0;
      in_a_q   <= 1'b0;
      in_b_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
`ifdef BASIC_GATE_BIST_LOG_EN
      fvalid_q <= 1'b0;
      fvec_q   <= '0;
      fobs_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      loop_q   <= loop_d;
      cnt_q    <= cnt_d;
      in_a_q   <= in_a_d;
      in_b_q   <= in_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
`ifdef BASIC_GATE_BIST_LOG_EN
      fvalid_q <= fvalid_d;
      fvec_q   <= fvec_d;
      fobs_q   <= fobs_d;
`endif
    end
  end

  // Next-state and registered-output logic; done is set only on FINISH entry.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    loop_d   = loop_q;
    cnt_d    = cnt_q;
    in_a_d   = in_a_q;
    in_b_d   = in_b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
`ifdef BASIC_GATE_BIST_LOG_EN
    fvalid_d = fvalid_q;
    fvec_d   = fvec_q;
    fobs_d   = fobs_q;
`endif

    unique case (state_q)
      IDLE: begin
        in_a_d = 1'b0;
        in_b_d = 1'b0;
        busy_d = 1'b0;
        if (start && !abort) begin
          err_d    = '0;
          pass_d   = 1'b0;
          vec_d    = '0;
          loop_d   = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = SETTLE;
`ifdef BASIC_GATE_BIST_LOG_EN
          fvalid_d = 1'b0;
          fvec_d   = '0;
          fobs_d   = '0;
`endif
        end
      end

      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          in_a_d  = 1'b0;
          in_b_d  = 1'b0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      CHECK: begin
        if (abort) begin
          state_d = IDLE;
          in_a_d  = 1'b0;
          in_b_d  = 1'b0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          err_d = err_q | mism_c;
`ifdef BASIC_GATE_BIST_LOG_EN
          if (!fvalid_q && (mism_c != '0)) begin
            fvalid_d = 1'b1;
            fvec_d   = vec_q;
            fobs_d   = gate_out;
          end
`endif
          if ((vec_q == VEC_W'(NUM_VECTORS - 1)) && (loop_q == LOOP_W'(LOOPS - 1))) begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_q + VEC_W'(1);
            if (vec_q == VEC_W'(NUM_VECTORS - 1)) begin
              loop_d = loop_q + LOOP_W'(1);
            end
            in_a_d  = vec_d[0];
            in_b_d  = vec_d[1];
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
        in_a_d  = 1'b0;
        in_b_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  assign in_a     = in_a_q;
  assign in_b     = in_b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_mask = err_q;
`ifdef BASIC_GATE_BIST_LOG_EN
  assign fail_valid = fvalid_q;
  assign fail_vec   = fvec_q;
  assign fail_obs   = fobs_q;
`endif

endmodule

// File: tb/tb_basic_gate_bist_ctrl.sv
// Directed bench for basic_gate_bist_ctrl: default build (SETTLE=2, LOOPS=1)
// plus a second instance with LOOPS=2, SETTLE_CYCLES=1.
module tb_basic_gate_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, force_xor0;
  logic       in_a, in_b, busy, done, pass;
  logic [6:0] err_mask, gate_out;

  logic       start2, abort2;
  logic       in_a2, in_b2, busy2, done2, pass2;
  logic [6:0] err2, gate_out2;

`ifdef BASIC_GATE_BIST_LOG_EN
  logic       fail_valid, fail_valid2;
  logic [1:0] fail_vec, fail_vec2;
  logic [6:0] fail_obs, fail_obs2;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  // Behavioural basic_gate, with an optional stuck-at-0 on the xor output.
  assign gate_out  = {~(in_a ^ in_b), force_xor0 ? 1'b0 : (in_a ^ in_b),
                      ~(in_a | in_b), in_a | in_b, ~(in_a & in_b), in_a & in_b, ~in_a};
  assign gate_out2 = {~(in_a2 ^ in_b2), in_a2 ^ in_b2, ~(in_a2 | in_b2), in_a2 | in_b2,
                      ~(in_a2 & in_b2), in_a2 & in_b2, ~in_a2};

  basic_gate_bist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_out(gate_out),
    .in_a(in_a), .in_b(in_b), .busy(busy), .done(done), .pass(pass), .err_mask(err_mask)
`ifdef BASIC_GATE_BIST_LOG_EN
    , .fail_valid(fail_valid), .fail_vec(fail_vec), .fail_obs(fail_obs)
`endif
  );

  basic_gate_bist_ctrl #(.SETTLE_CYCLES(1), .LOOPS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .gate_out(gate_out2),
    .in_a(in_a2), .in_b(in_b2), .busy(busy2), .done(done2), .pass(pass2), .err_mask(err2)
`ifdef BASIC_GATE_BIST_LOG_EN
    , .fail_valid(fail_valid2), .fail_vec(fail_vec2), .fail_obs(fail_obs2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start so it is taken on the next edge (edge 0); returns 1 after edge 0.
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Full default run from IDLE; checks pin sequence, done timing and result.
  task automatic run_default(input logic [6:0] exp_mask, input logic exp_pass);
    logic [1:0] vv;
    kick();
    for (int e = 0; e < 12; e++) begin
      vv = 2'(e / 3);
      check("pin_a", {31'd0, in_a}, {31'd0, vv[0]});
      check("pin_b", {31'd0, in_b}, {31'd0, vv[1]});
      check("busy_run", {31'd0, busy}, 32'd1);
      check("done_early", {31'd0, done}, 32'd0);
      step();
    end
    check("done_e12", {31'd0, done}, 32'd1);
    check("busy_fin", {31'd0, busy}, 32'd0);
    check("pass", {31'd0, pass}, {31'd0, exp_pass});
    check("err_mask", {25'd0, err_mask}, {25'd0, exp_mask});
    step();
    check("done_pulse", {31'd0, done}, 32'd0);
    check("pins_idle", {30'd0, in_b, in_a}, 32'd0);
    check("pass_held", {31'd0, pass}, {31'd0, exp_pass});
  endtask

  // Abort taken on edge ab_edge; verifies quiet return to IDLE.
  task automatic abort_at(input int ab_edge, input logic [6:0] exp_mask);
    int seen;
    kick();
    for (int e = 1; e < ab_edge; e++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_pins", {30'd0, in_b, in_a}, 32'd0);
    check("abort_pass", {31'd0, pass}, 32'd0);
    check("abort_mask", {25'd0, err_mask}, {25'd0, exp_mask});
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) seen++;
      step();
    end
    check("abort_quiet", seen, 0);
  endtask

  initial begin
    int dones, done_edge;
    logic [1:0] vv;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; force_xor0 = 1'b0;
    start2 = 1'b0; abort2 = 1'b0;
    step(); step();
    check("rst_outs", {25'd0, err_mask, busy, done, pass, in_a, in_b}, 32'd0);
    check("rst_outs2", {25'd0, err2, busy2, done2, pass2, in_a2, in_b2}, 32'd0);
    rst_n = 1'b1;
    step();

    // Healthy datapath.
    run_default(7'b0000000, 1'b1);

    // xor stuck at 0: mismatches on vectors 1 and 2.
    force_xor0 = 1'b1;
    run_default(7'b0100000, 1'b0);
`ifdef BASIC_GATE_BIST_LOG_EN
    check("log_valid", {31'd0, fail_valid}, 32'd1);
    check("log_vec", {30'd0, fail_vec}, 32'd1);
    check("log_obs", {25'd0, fail_obs}, 32'b0001100);
`endif
    force_xor0 = 1'b0;

    // Abort early, then abort after a recorded mismatch (mask retained).
    abort_at(5, 7'b0000000);
    force_xor0 = 1'b1;
    abort_at(8, 7'b0100000);
    force_xor0 = 1'b0;

    // Start during the run and during FINISH is ignored: single done at edge 12.
    kick();
    dones = 0; done_edge = -1;
    for (int e = 1; e <= 25; e++) begin
      start = (e == 5 || e == 13);
      step();
      if (done) begin
        dones++;
        done_edge = e;
      end
    end
    start = 1'b0;
    check("one_done", dones, 1);
    check("done_edge", done_edge, 12);
    check("idle_after", {31'd0, busy}, 32'd0);

    // Start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("sa_busy", {31'd0, busy}, 32'd0);
    check("sa_pins", {30'd0, in_b, in_a}, 32'd0);
    step();
    check("sa_busy2", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-run, after vector 1 was checked at edge 6.
    force_xor0 = 1'b1;
    kick();
    for (int e = 1; e <= 7; e++) step();
    check("pre_rst_mask", {25'd0, err_mask}, 32'b0100000);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {25'd0, err_mask, busy, done, pass, in_a, in_b}, 32'd0);
`ifdef BASIC_GATE_BIST_LOG_EN
    check("async_rst_log", {22'd0, fail_valid, fail_vec, fail_obs}, 32'd0);
`endif
    step();
    check("rst_no_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    force_xor0 = 1'b0;
    step();
    run_default(7'b0000000, 1'b1);

    // LOOPS=2, SETTLE_CYCLES=1: 8 vectors of 2 cycles, done after edge 16.
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int e = 0; e < 16; e++) begin
      vv = 2'((e / 2) % 4);
      check("p2_pins", {30'd0, in_b2, in_a2}, {30'd0, vv[1], vv[0]});
      check("p2_done_early", {31'd0, done2}, 32'd0);
      step();
    end
    check("p2_done_e16", {31'd0, done2}, 32'd1);
    check("p2_pass", {31'd0, pass2}, 32'd1);
    check("p2_mask", {25'd0, err2}, 32'd0);
    check("p2_busy", {31'd0, busy2}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
